// File: rtl/divisor_secuencial_8bits_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and counter sizing.
// Optional build macro: DIV_SIGNED_EN (two's complement operands).
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } div_state_t;

    // Step counter must be able to hold the value WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/divisor_secuencial_8bits_if.sv
// Control-unit side bus of the divider: request operands in, result and status out.
interface divisor_secuencial_8bits_if #(
    parameter int WIDTH = 8
);
    // Handshake: start acts as valid and is only accepted while the divider is idle
    // (not busy, not finishing); there is no ready, a start that is not accepted is dropped.
    // done is a one-cycle pulse marking Q/R/div_zero/overflow as valid; they hold afterwards.
    logic             start;
    logic [WIDTH-1:0] Ai;
    logic [WIDTH-1:0] Bi;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             overflow;

    modport master (
        output start, Ai, Bi,
        input  Q, R, busy, done, div_zero, overflow
    );

    modport slave (
        input  start, Ai, Bi,
        output Q, R, busy, done, div_zero, overflow
    );

endinterface

// File: rtl/divisor_secuencial_8bits_etapa.sv
// One restoring-division step: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and shift the resulting quotient bit into the dividend register.
module etapa_resta_restauradora #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dvd_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           q_bit;

    // The dividend register doubles as the quotient register: bits leave at the top
    // and quotient bits enter at the bottom, so after WIDTH steps it holds Q.
    always_comb begin
        rem_sh = {rem_i, dvd_i[WIDTH-1]};
        trial  = rem_sh - {1'b0, divisor_i};
        q_bit  = ~trial[WIDTH];
        rem_o  = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        dvd_o  = {dvd_i[WIDTH-2:0], q_bit};
    end

endmodule

// File: rtl/divisor_secuencial_8bits.sv
// Sequential restoring divider (IDLE -> CALC x WIDTH -> FIN), results registered on leaving FIN.
// Optional build macro: DIV_SIGNED_EN (signed operands, truncation toward zero, overflow flag).
module divisor_secuencial_8bits
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    divisor_secuencial_8bits_if.slave   bus,
    output div_state_t                  state_dbg
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_dvd;

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic negq_q, negq_d;
    logic negr_q, negr_d;
    logic ovf_q, ovf_d;
    logic overflow_q, overflow_d;

    assign mag_a = bus.Ai[WIDTH-1] ? (-bus.Ai) : bus.Ai;
    assign mag_b = bus.Bi[WIDTH-1] ? (-bus.Bi) : bus.Bi;
    assign bus.overflow = overflow_q;
`else
    assign mag_a = bus.Ai;
    assign mag_b = bus.Bi;
    assign bus.overflow = 1'b0;
`endif

    etapa_resta_restauradora #(
        .WIDTH (WIDTH)
    ) u_etapa (
        .rem_i     (rem_q),
        .dvd_i     (dvd_q),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .dvd_o     (step_dvd)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        q_d        = q_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
`ifdef DIV_SIGNED_EN
        negq_d     = negq_q;
        negr_d     = negr_q;
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    div_zero_d = 1'b0;
                    rem_d      = '0;
                    cnt_d      = '0;
`ifdef DIV_SIGNED_EN
                    overflow_d = 1'b0;
                    negq_d     = bus.Ai[WIDTH-1] ^ bus.Bi[WIDTH-1];
                    negr_d     = bus.Ai[WIDTH-1];
                    ovf_d      = (bus.Ai == MOST_NEG) && (bus.Bi == '1);
`endif
                    if (bus.Bi == '0) begin
                        // Divide-by-zero skips CALC; raw Ai is kept to report as R.
                        dz_d    = 1'b1;
                        dvd_d   = bus.Ai;
                        state_d = ST_FIN;
                    end else begin
                        dz_d    = 1'b0;
                        dvd_d   = mag_a;
                        dsr_d   = mag_b;
                        busy_d  = 1'b1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                dvd_d = step_dvd;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
                if (dz_q) begin
                    q_d        = '1;
                    r_d        = dvd_q;
                    div_zero_d = 1'b1;
                end else begin
`ifdef DIV_SIGNED_EN
                    q_d        = negq_q ? (-dvd_q) : dvd_q;
                    r_d        = negr_q ? (-rem_q) : rem_q;
                    overflow_d = ovf_q;
`else
                    q_d        = dvd_q;
                    r_d        = rem_q;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            q_q        <= q_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
`ifdef DIV_SIGNED_EN
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign bus.Q        = q_q;
    assign bus.R        = r_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_divisor_secuencial_8bits.sv
// Bench for divisor_secuencial_8bits: vector table, ignored-start and mid-operation reset
// sequences, and a random sweep, with results checked through an expected-result queue.
module tb_divisor_secuencial_8bits;
    import div_pkg::*;

    localparam int W  = 8;
    localparam int EW = 2 * W + 2;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } vec_t;

    logic       clk;
    logic       rst;
    div_state_t state_dbg;

    divisor_secuencial_8bits_if #(.WIDTH(W)) bus ();

    divisor_secuencial_8bits #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    logic [EW-1:0] exp_q[$];
    int            total;
    int            bad;
    int            done_cnt;
    logic [2*W-1:0] last_qr;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] q, r;
        logic         dz, ovf;
        logic signed [W-1:0] sa, sb;
        sa  = a;
        sb  = b;
        dz  = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
`ifdef DIV_SIGNED_EN
            if (a == 8'h80 && b == 8'hFF) begin
                q   = 8'h80;
                r   = '0;
                ovf = 1'b1;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
        return {q, r, dz, ovf};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: done=1 with no pending result at %0t", $time);
            end else begin
                chk("result{Q,R,dz,ovf}",
                    {{(32-EW){1'b0}}, bus.Q, bus.R, bus.div_zero, bus.overflow},
                    {{(32-EW){1'b0}}, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] e);
        int n, nb, exp_lat;
        exp_lat = (b == 0) ? 2 : W + 2;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.Ai    = a;
        bus.Bi    = b;
        @(negedge clk);
        bus.start = 1'b0;
        chk("flags_cleared_on_accept", {bus.div_zero, bus.overflow}, 2'b00);
        chk("qr_held_after_accept", {bus.Q, bus.R}, last_qr);
        n  = 1;
        nb = 0;
        while (!bus.done && n < 64) begin
            if (bus.busy) nb++;
            @(negedge clk);
            n++;
        end
        chk("done_seen", bus.done, 1'b1);
        chk("latency", n, exp_lat);
        chk("busy_cycles", nb, exp_lat - 2);
        last_qr = e[EW-1:2];
        @(negedge clk);
        chk("done_one_cycle", bus.done, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    vec_t tbl[8];

    initial begin
        int           n, dc0;
        logic [W-1:0] a, b;
        logic [EW-1:0] e;

        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        last_qr   = '0;
        bus.start = 1'b0;
        bus.Ai    = '0;
        bus.Bi    = '0;

`ifdef DIV_SIGNED_EN
        tbl[0] = '{8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0};
        tbl[1] = '{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1};
        tbl[2] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0};
        tbl[3] = '{8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1'b0};
        tbl[4] = '{8'h9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0};
        tbl[5] = '{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0};
        tbl[7] = '{8'h7F, 8'hFF, 8'h81, 8'h00, 1'b0, 1'b0};
`else
        tbl[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b0};
        tbl[1] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b0};
        tbl[2] = '{8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 1'b0};
        tbl[3] = '{8'd42, 8'd0, 8'hFF, 8'd42, 1'b1, 1'b0};
        tbl[4] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0};
        tbl[5] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b0};
        tbl[6] = '{8'd128, 8'd3, 8'd42, 8'd2, 1'b0, 1'b0};
        tbl[7] = '{8'd1, 8'd255, 8'd0, 8'd1, 1'b0, 1'b0};
`endif

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_Q", bus.Q, 0);
        chk("rst_R", bus.R, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", {bus.div_zero, bus.overflow}, 2'b00);
        chk("rst_state", state_dbg, ST_IDLE);
        rst = 1'b0;
        @(negedge clk);

        // table vectors (includes divide-by-zero followed by a valid start)
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].ovf});
        end

        // start re-asserted with new operands during CALC is ignored
        dc0 = done_cnt;
        exp_q.push_back({8'd14, 8'd2, 1'b0, 1'b0});
        bus.start = 1'b1;
        bus.Ai    = 8'd100;
        bus.Bi    = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.Ai    = 8'd200;
        bus.Bi    = 8'd3;
        repeat (3) @(negedge clk);
        chk("qr_held_during_calc", {bus.Q, bus.R}, last_qr);
        bus.start = 1'b0;
        n = 6;
        while (!bus.done && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("ignore_latency", n, W + 2);
        last_qr = {8'd14, 8'd2};
        repeat (12) @(negedge clk);
        chk("ignore_single_done", done_cnt - dc0, 1);

        // asynchronous reset in the middle of CALC
        bus.start = 1'b1;
        bus.Ai    = 8'd200;
        bus.Bi    = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", bus.busy, 1);
        dc0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_QR", {bus.Q, bus.R}, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_state", state_dbg, ST_IDLE);
        @(negedge clk);
        rst     = 1'b0;
        last_qr = '0;
        repeat (14) @(negedge clk);
        chk("abort_no_done", done_cnt - dc0, 0);
        run_op(8'd100, 8'd7, {8'd14, 8'd2, 1'b0, 1'b0});

        // random sweep
        for (int i = 0; i < 24; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 8 == 7) ? 8'd0 : 8'($urandom_range(1, 255));
            e = model(a, b);
            run_op(a, b, e);
`ifndef DIV_SIGNED_EN
            if (b != 0) begin
                chk("identity_a_eq_qb_plus_r", 32'(bus.Q) * 32'(b) + 32'(bus.R), 32'(a));
                chk("remainder_below_divisor", (bus.R < b) ? 1 : 0, 1);
            end
`endif
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
